// File: rtl/cnn1d_pkg.sv
// Shared definitions for the 1-D CNN datapath: default sample width and the
// activation-function selector used by activation_unit and activation_lane.
package cnn1d_pkg;

  localparam int DEFAULT_DATA_WIDTH = 12;

  typedef enum logic [1:0] {
    ACT_PASS  = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_LEAKY = 2'd2,
    ACT_CLIP  = 2'd3
  } act_mode_t;

endpackage

// File: rtl/activation_lane.sv
// Single-channel combinational activation: pass, ReLU, leaky ReLU
// (arithmetic shift, rounds toward minus infinity) or clipped ReLU.
// The result never grows beyond DATA_WIDTH.
module activation_lane
  import cnn1d_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int LEAKY_SHIFT = 3
) (
  input  act_mode_t                     i_mode,
  input  logic signed [DATA_WIDTH-1:0]  i_clip_max,
  input  logic signed [DATA_WIDTH-1:0]  i_data,
  output logic signed [DATA_WIDTH-1:0]  o_data
);

  logic w_neg;
  assign w_neg = i_data[DATA_WIDTH-1];

  // Select the activated value; default is the untouched input.
  always_comb begin
    o_data = i_data;
    case (i_mode)
      ACT_PASS:  o_data = i_data;
      ACT_RELU:  if (w_neg) o_data = '0;
      ACT_LEAKY: if (w_neg) o_data = i_data >>> LEAKY_SHIFT;
      ACT_CLIP: begin
        if (w_neg)                     o_data = '0;
        else if (i_data > i_clip_max)  o_data = i_clip_max;
      end
      default:   o_data = i_data;
    endcase
  end

endmodule

// File: rtl/activation_unit.sv
// Two-stage valid/ready activation pipeline over CHANNELS packed samples.
// Stage 1 captures the beat with the act_mode/clip_max seen at its transfer;
// stage 2 holds the activated result. Optional macro ACTIVATION_STATS_EN adds
// clamp_count, a saturating count of output beats altered by activation.
//
// Handshake: a beat moves across a port on any rising edge where that port's
// valid and ready are both high; valid never depends on ready, data and
// valid hold steady while valid is high and ready is low.
module activation_unit
  import cnn1d_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int CHANNELS    = 4,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [1:0]                     act_mode,
  input  logic [DATA_WIDTH-1:0]          clip_max,
  output logic                           act_ready_in,
  input  logic                           act_valid_in,
  input  logic [CHANNELS*DATA_WIDTH-1:0] act_data_in,
  input  logic                           act_ready_out,
  output logic                           act_valid_out,
  output logic [CHANNELS*DATA_WIDTH-1:0] act_data_out
`ifdef ACTIVATION_STATS_EN
  ,
  output logic [31:0]                    clamp_count
`endif
);

  localparam int BW = CHANNELS * DATA_WIDTH;

  logic            r_s1_valid;
  logic [BW-1:0]   r_s1_data;
  act_mode_t       r_s1_mode;
  logic [DATA_WIDTH-1:0] r_s1_clip;
  logic            r_s2_valid;
  logic [BW-1:0]   r_s2_data;
  logic [BW-1:0]   w_act;
  logic            w_s2_ready;
  logic            w_s1_accept;

  // Stage 2 can take a beat when empty or when its beat is leaving.
  assign w_s2_ready   = !r_s2_valid || act_ready_out;
  assign act_ready_in = !rst && (!r_s1_valid || w_s2_ready);
  assign w_s1_accept  = act_valid_in && act_ready_in;

  assign act_valid_out = r_s2_valid;
  assign act_data_out  = r_s2_data;

  // Per-channel activation on the stage-1 beat using its captured mode.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    activation_lane #(
      .DATA_WIDTH  (DATA_WIDTH),
      .LEAKY_SHIFT (LEAKY_SHIFT)
    ) u_lane (
      .i_mode     (r_s1_mode),
      .i_clip_max (r_s1_clip),
      .i_data     (r_s1_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .o_data     (w_act[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Stage 1: capture beat plus mode/clip; empty once it moves to stage 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_mode  <= ACT_PASS;
      r_s1_clip  <= '0;
    end else if (w_s1_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_data  <= act_data_in;
      r_s1_mode  <= act_mode_t'(act_mode);
      r_s1_clip  <= clip_max;
    end else if (w_s2_ready) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2: register the activated result whenever it has room.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) r_s2_data <= w_act;
    end
  end

`ifdef ACTIVATION_STATS_EN
  logic [CHANNELS-1:0] w_clamped;
  logic                r_s2_clamped;
  logic [31:0]         r_clamp_count;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_clamp
    assign w_clamped[c] = (w_act[c*DATA_WIDTH +: DATA_WIDTH] !=
                           r_s1_data[c*DATA_WIDTH +: DATA_WIDTH]);
  end

  // Remember whether the stage-2 beat differs from its input anywhere.
  always_ff @(posedge clk) begin
    if (rst)                          r_s2_clamped <= 1'b0;
    else if (w_s2_ready && r_s1_valid) r_s2_clamped <= |w_clamped;
  end

  // Count altered beats as they leave, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst)
      r_clamp_count <= '0;
    else if (r_s2_valid && act_ready_out && r_s2_clamped && (r_clamp_count != '1))
      r_clamp_count <= r_clamp_count + 32'd1;
  end

  assign clamp_count = r_clamp_count;
`endif

endmodule

// File: tb/tb_activation_unit.sv
// Directed bench for activation_unit: reset state, every activation mode,
// mode sampling per beat, backpressure ordering/stability and mid-stream reset.
module tb_activation_unit;
  localparam int DW = 12;
  localparam int CH = 4;
  localparam int BW = DW * CH;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    act_mode;
  logic [DW-1:0] clip_max;
  logic          act_ready_in;
  logic          act_valid_in;
  logic [BW-1:0] act_data_in;
  logic          act_ready_out;
  logic          act_valid_out;
  logic [BW-1:0] act_data_out;
`ifdef ACTIVATION_STATS_EN
  logic [31:0]   clamp_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Clock / reset
  always #5 clk = ~clk;

  activation_unit #(.DATA_WIDTH(DW), .CHANNELS(CH), .LEAKY_SHIFT(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .act_mode      (act_mode),
    .clip_max      (clip_max),
    .act_ready_in  (act_ready_in),
    .act_valid_in  (act_valid_in),
    .act_data_in   (act_data_in),
    .act_ready_out (act_ready_out),
    .act_valid_out (act_valid_out),
    .act_data_out  (act_data_out)
`ifdef ACTIVATION_STATS_EN
    ,
    .clamp_count   (clamp_count)
`endif
  );

  function automatic logic [BW-1:0] pk(input int c0, input int c1, input int c2, input int c3);
    logic [31:0] a, b, c, d;
    a = c0; b = c1; c = c2; d = c3;
    return {d[DW-1:0], c[DW-1:0], b[DW-1:0], a[DW-1:0]};
  endfunction

  function automatic logic [BW-1:0] stream_beat(input int s);
    return pk(s * 3 + 1, -(s + 2), s * 100, 2000 - s);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Driver: one beat into an empty pipeline, output checked at N+1 and N+2.
  task automatic send_one(input string tag, input logic [1:0] mode, input logic [DW-1:0] clip,
                          input logic [BW-1:0] din, input logic [BW-1:0] exp);
    act_mode = mode; clip_max = clip; act_data_in = din; act_valid_in = 1'b1;
    chk({tag, "_rdy"}, 64'(act_ready_in), 64'd1);
    step();
    act_valid_in = 1'b0;
    act_mode = ~mode; clip_max = '0; act_data_in = '0;
    chk({tag, "_v1"}, 64'(act_valid_out), 64'd0);
    step();
    chk({tag, "_v2"}, 64'(act_valid_out), 64'd1);
    chk({tag, "_d2"}, 64'(act_data_out), 64'(exp));
    step();
    chk({tag, "_v3"}, 64'(act_valid_out), 64'd0);
  endtask

  logic [BW-1:0] exp_q[$];

  initial begin
    int sent, got;
    bit prev_stall, saw_rdy_low;
    logic [BW-1:0] prev_data;

    rst = 1'b1; act_mode = 2'd0; clip_max = '0; act_valid_in = 1'b0;
    act_data_in = '0; act_ready_out = 1'b1;
    step(); step();
    chk("rst_rdy_in", 64'(act_ready_in), 64'd0);
    chk("rst_vout",   64'(act_valid_out), 64'd0);
    chk("rst_dout",   64'(act_data_out), 64'd0);
`ifdef ACTIVATION_STATS_EN
    chk("rst_cnt",    64'(clamp_count), 64'd0);
`endif
    rst = 1'b0; #1;
    chk("post_rst_rdy", 64'(act_ready_in), 64'd1);

    send_one("relu",  2'd1, 12'd0,   pk(-5, 0, 7, 2047),      pk(0, 0, 7, 2047));
    send_one("leaky", 2'd2, 12'd0,   pk(-16, -1, 8, -2048),   pk(-2, -1, 8, -256));
    send_one("clip",  2'd3, 12'd100, pk(-3, 50, 100, 500),    pk(0, 50, 100, 100));
    send_one("pass",  2'd0, 12'd5,   pk(-7, 300, -2048, 2047), pk(-7, 300, -2048, 2047));

    // Mode switch between back-to-back beats of -4.
    act_data_in = pk(-4, -4, -4, -4); act_valid_in = 1'b1; act_mode = 2'd1;
    step();
    act_mode = 2'd0;
    step();
    act_valid_in = 1'b0; act_mode = 2'd1;
    chk("sw_v0", 64'(act_valid_out), 64'd1);
    chk("sw_d0", 64'(act_data_out), 64'(pk(0, 0, 0, 0)));
    step();
    chk("sw_v1", 64'(act_valid_out), 64'd1);
    chk("sw_d1", 64'(act_data_out), 64'(pk(-4, -4, -4, -4)));
    step();
    chk("sw_idle", 64'(act_valid_out), 64'd0);
`ifdef ACTIVATION_STATS_EN
    chk("sw_cnt", 64'(clamp_count), 64'd4);
`endif

    // Backpressure stream: ready_out follows 1,0,0,1.
    act_mode = 2'd0; sent = 0; got = 0; prev_stall = 0; saw_rdy_low = 0; prev_data = '0;
    for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
      act_ready_out = (cyc % 4 == 0) || (cyc % 4 == 3);
      act_valid_in  = (sent < 10);
      act_data_in   = stream_beat(sent);
      #1;
      if (prev_stall) chk("bp_stable", 64'(act_data_out), 64'(prev_data));
      if (!act_ready_in) begin
        saw_rdy_low = 1;
        chk("bp_rdy_low_ok", 64'(act_valid_out && !act_ready_out), 64'd1);
      end
      if (act_valid_in && act_ready_in) begin
        exp_q.push_back(stream_beat(sent));
        sent++;
      end
      if (act_valid_out && act_ready_out) begin
        if (exp_q.size() == 0) chk("bp_extra", 64'd1, 64'd0);
        else chk("bp_data", 64'(act_data_out), 64'(exp_q.pop_front()));
        got++;
      end
      prev_stall = act_valid_out && !act_ready_out;
      prev_data  = act_data_out;
      @(posedge clk); #1;
    end
    act_valid_in = 1'b0; act_ready_out = 1'b1;
    chk("bp_count", 64'(got), 64'd10);
    chk("bp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("bp_saw_full", 64'(saw_rdy_low), 64'd1);
    step();
    chk("bp_idle", 64'(act_valid_out), 64'd0);

    // Two beats in flight held by backpressure, then a one-cycle reset.
    act_ready_out = 1'b0; act_mode = 2'd0;
    act_data_in = pk(11, 22, 33, 44); act_valid_in = 1'b1;
    step();
    act_data_in = pk(55, 66, 77, 88);
    step();
    act_valid_in = 1'b0;
    chk("fl_vout", 64'(act_valid_out), 64'd1);
    rst = 1'b1; #1;
    chk("fl_rst_rdy", 64'(act_ready_in), 64'd0);
    step();
    rst = 1'b0; act_ready_out = 1'b1; #1;
    chk("fl_vout0", 64'(act_valid_out), 64'd0);
    chk("fl_dout0", 64'(act_data_out), 64'd0);
    chk("fl_rdy", 64'(act_ready_in), 64'd1);
    step();
    chk("fl_vout1", 64'(act_valid_out), 64'd0);
    step();
    chk("fl_vout2", 64'(act_valid_out), 64'd0);
`ifdef ACTIVATION_STATS_EN
    chk("fl_cnt", 64'(clamp_count), 64'd0);
`endif
    send_one("fl_new", 2'd1, 12'd0, pk(-9, 9, -1, 1), pk(0, 9, 0, 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
